spi_cmd_decoder: RTL and testbench

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_decoder_if.sv | 32 +++
 rtl/spi_cmd_decoder.sv | 157 +++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_if.sv
// Signal bundle between the SPI byte engine, the reply path and the memory bus.
// master is the command decoder; slave is the surrounding SPI core and bus fabric.
interface spi_cmd_decoder_if;
    logic        i_active;
    logic        i_rx_valid;
    logic        i_rx_start;
    logic [7:0]  i_rx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [7:0]  o_tx_data;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [15:0] o_bus_addr;
    logic [7:0]  o_bus_wdata;
    logic        i_bus_ack;
    logic [7:0]  i_bus_rdata;
    logic        o_busy;

    modport master (
        input  i_active, i_rx_valid, i_rx_start, i_rx_data, i_tx_ready,
               i_bus_ack, i_bus_rdata,
        output o_tx_valid, o_tx_data, o_bus_req, o_bus_we, o_bus_addr,
               o_bus_wdata, o_busy
    );

    modport slave (
        output i_active, i_rx_valid, i_rx_start, i_rx_data, i_tx_ready,
               i_bus_ack, i_bus_rdata,
        input  o_tx_valid, o_tx_data, o_bus_req, o_bus_we, o_bus_addr,
               o_bus_wdata, o_busy
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command byte streams (WRITE / READ / STATUS) into single-byte
// memory bus transactions with auto-incrementing address and sticky error flags.
module spi_cmd_decoder (
    input  logic              i_clock,
    input  logic              i_reset,
    spi_cmd_decoder_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, WDATA, WBUS, RFETCH, RHOLD, STATUS, DISCARD
    } state_t;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    state_t      state_reg;
    logic [15:0] addr_reg;
    logic [7:0]  wdata_reg;
    logic [7:0]  tx_data_reg;
    logic        tx_valid_reg;
    logic        bus_req_reg;
    logic        bus_we_reg;
    logic        is_write_reg;
    logic        overrun_reg;
    logic        bad_cmd_reg;
    logic        abort_reg;

    logic rx_byte;
    logic rx_cmd;
    logic resync;
    logic known_cmd;
    logic set_overrun;
    logic set_bad;
    logic clr_flags;

    always_comb begin
        rx_byte     = bus.i_rx_valid && !bus.i_rx_start;
        rx_cmd      = bus.i_rx_valid && bus.i_rx_start && bus.i_active && !abort_reg;
        // A command byte restarts decoding anywhere but DISCARD, yet never abandons a live request
        resync      = rx_cmd && !bus_req_reg && (state_reg != DISCARD);
        known_cmd   = (bus.i_rx_data == CMD_WRITE) || (bus.i_rx_data == CMD_READ) ||
                      (bus.i_rx_data == CMD_STATUS);
        set_bad     = resync && !known_cmd;
        set_overrun = bus.i_active && bus.i_rx_valid && bus_req_reg &&
                      (bus.i_rx_start || state_reg == WBUS);
        clr_flags   = (state_reg == STATUS) && bus.i_tx_ready;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            addr_reg     <= 16'h0000;
            wdata_reg    <= 8'h00;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
            bus_req_reg  <= 1'b0;
            bus_we_reg   <= 1'b0;
            is_write_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            bad_cmd_reg  <= 1'b0;
            abort_reg    <= 1'b0;
        end else begin
            // Setting a flag takes priority over the clear caused by reading STATUS
            overrun_reg <= set_overrun || (overrun_reg && !clr_flags);
            bad_cmd_reg <= set_bad || (bad_cmd_reg && !clr_flags);

            if (!bus.i_active || abort_reg) begin
                tx_valid_reg <= 1'b0;
                if (bus_req_reg && !bus.i_bus_ack) begin
                    abort_reg <= 1'b1;
                end else begin
                    state_reg   <= IDLE;
                    bus_req_reg <= 1'b0;
                    bus_we_reg  <= 1'b0;
                    abort_reg   <= 1'b0;
                end
            end else if (resync) begin
                case (bus.i_rx_data)
                    CMD_WRITE: begin
                        is_write_reg <= 1'b1;
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ADDR_HI;
                    end
                    CMD_READ: begin
                        is_write_reg <= 1'b0;
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ADDR_HI;
                    end
                    CMD_STATUS: begin
                        tx_data_reg  <= {6'b0, overrun_reg, bad_cmd_reg};
                        tx_valid_reg <= 1'b1;
                        state_reg    <= STATUS;
                    end
                    default: begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= DISCARD;
                    end
                endcase
            end else begin
                case (state_reg)
                    ADDR_HI: if (rx_byte) begin
                        addr_reg[15:8] <= bus.i_rx_data;
                        state_reg      <= ADDR_LO;
                    end
                    ADDR_LO: if (rx_byte) begin
                        addr_reg[7:0] <= bus.i_rx_data;
                        if (is_write_reg) begin
                            state_reg <= WDATA;
                        end else begin
                            bus_req_reg <= 1'b1;
                            bus_we_reg  <= 1'b0;
                            state_reg   <= RFETCH;
                        end
                    end
                    WDATA: if (rx_byte) begin
                        wdata_reg   <= bus.i_rx_data;
                        bus_req_reg <= 1'b1;
                        bus_we_reg  <= 1'b1;
                        state_reg   <= WBUS;
                    end
                    WBUS: if (bus.i_bus_ack) begin
                        bus_req_reg <= 1'b0;
                        bus_we_reg  <= 1'b0;
                        addr_reg    <= addr_reg + 16'd1;
                        state_reg   <= WDATA;
                    end
                    RFETCH: if (bus.i_bus_ack) begin
                        bus_req_reg  <= 1'b0;
                        tx_data_reg  <= bus.i_bus_rdata;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= RHOLD;
                    end
                    RHOLD: if (bus.i_tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        addr_reg     <= addr_reg + 16'd1;
                        bus_req_reg  <= 1'b1;
                        bus_we_reg   <= 1'b0;
                        state_reg    <= RFETCH;
                    end
                    STATUS: if (bus.i_tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_tx_valid  = tx_valid_reg;
    assign bus.o_tx_data   = tx_data_reg;
    assign bus.o_bus_req   = bus_req_reg;
    assign bus.o_bus_we    = bus_we_reg;
    assign bus.o_bus_addr  = addr_reg;
    assign bus.o_bus_wdata = wdata_reg;
    assign bus.o_busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed-plus-random bench for spi_cmd_decoder; a byte-array memory model
// supplies read data and predicts every reply, address and status value.
module tb_spi_cmd_decoder;
    logic clk;
    logic rst;

    spi_cmd_decoder_if ifc ();

    spi_cmd_decoder dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] mem [65536];
    logic       exp_overrun = 1'b0;
    logic       exp_bad     = 1'b0;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic start, input logic [7:0] data);
        ifc.i_rx_valid = 1'b1;
        ifc.i_rx_start = start;
        ifc.i_rx_data  = data;
        tick();
        ifc.i_rx_valid = 1'b0;
        ifc.i_rx_start = 1'b0;
    endtask

    task automatic bus_ack(input logic [7:0] rdata);
        ifc.i_bus_ack   = 1'b1;
        ifc.i_bus_rdata = rdata;
        tick();
        ifc.i_bus_ack   = 1'b0;
    endtask

    task automatic tx_take();
        ifc.i_tx_ready = 1'b1;
        tick();
        ifc.i_tx_ready = 1'b0;
    endtask

    task automatic deselect();
        ifc.i_active = 1'b0;
        tick();
        chk("deselect_busy", ifc.o_busy, 0);
        chk("deselect_tx_valid", ifc.o_tx_valid, 0);
        ifc.i_active = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tx_valid"}, ifc.o_tx_valid, 0);
        chk({tag, "_tx_data"}, ifc.o_tx_data, 0);
        chk({tag, "_bus_req"}, ifc.o_bus_req, 0);
        chk({tag, "_bus_we"}, ifc.o_bus_we, 0);
        chk({tag, "_bus_addr"}, ifc.o_bus_addr, 0);
        chk({tag, "_bus_wdata"}, ifc.o_bus_wdata, 0);
        chk({tag, "_busy"}, ifc.o_busy, 0);
    endtask

    // Burst write of data[] starting at a; delay < 0 picks a random ack delay per byte.
    task automatic write_txn(input logic [15:0] a, input logic [7:0] data[$], input int delay);
        logic [15:0] ea;
        int          dl;
        send(1'b1, 8'h01);
        chk("wr_cmd_busy", ifc.o_busy, 1);
        send(1'b0, a[15:8]);
        send(1'b0, a[7:0]);
        chk("wr_no_req_before_data", ifc.o_bus_req, 0);
        for (int i = 0; i < data.size(); i++) begin
            ea = a + 16'(i);
            send(1'b0, data[i]);
            chk("wr_req", ifc.o_bus_req, 1);
            chk("wr_we", ifc.o_bus_we, 1);
            chk("wr_addr", ifc.o_bus_addr, ea);
            chk("wr_wdata", ifc.o_bus_wdata, data[i]);
            dl = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
            for (int k = 0; k < dl; k++) begin
                tick();
                chk("wr_hold_req", ifc.o_bus_req, 1);
                chk("wr_hold_addr", ifc.o_bus_addr, ea);
            end
            bus_ack(8'h00);
            chk("wr_release", ifc.o_bus_req, 0);
            mem[ea] = data[i];
        end
        deselect();
    endtask

    task automatic status_txn();
        send(1'b1, 8'h03);
        chk("st_tx_valid", ifc.o_tx_valid, 1);
        chk("st_tx_data", ifc.o_tx_data, {6'b0, exp_overrun, exp_bad});
        tick(2);
        chk("st_hold_valid", ifc.o_tx_valid, 1);
        tx_take();
        chk("st_taken_valid", ifc.o_tx_valid, 0);
        chk("st_taken_busy", ifc.o_busy, 0);
        exp_overrun = 1'b0;
        exp_bad     = 1'b0;
    endtask

    // Burst read of n bytes from a, then abandon the prefetch by deselecting.
    task automatic read_txn(input logic [15:0] a, input int n);
        logic [15:0] ea;
        send(1'b1, 8'h02);
        send(1'b0, a[15:8]);
        send(1'b0, a[7:0]);
        for (int i = 0; i < n; i++) begin
            ea = a + 16'(i);
            chk("rd_req", ifc.o_bus_req, 1);
            chk("rd_we", ifc.o_bus_we, 0);
            chk("rd_addr", ifc.o_bus_addr, ea);
            send(1'b0, 8'hFF);
            tick($urandom_range(0, 3));
            chk("rd_hold_req", ifc.o_bus_req, 1);
            chk("rd_no_tx_yet", ifc.o_tx_valid, 0);
            bus_ack(mem[ea]);
            chk("rd_release", ifc.o_bus_req, 0);
            chk("rd_tx_valid", ifc.o_tx_valid, 1);
            chk("rd_tx_data", ifc.o_tx_data, mem[ea]);
            tick($urandom_range(0, 2));
            chk("rd_tx_hold", ifc.o_tx_data, mem[ea]);
            tx_take();
            chk("rd_tx_taken", ifc.o_tx_valid, 0);
        end
        ea = a + 16'(n);
        chk("rd_prefetch_req", ifc.o_bus_req, 1);
        chk("rd_prefetch_addr", ifc.o_bus_addr, ea);
        ifc.i_active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_req_held", ifc.o_bus_req, 1);
            chk("abort_no_tx", ifc.o_tx_valid, 0);
        end
        bus_ack(8'($urandom));
        chk("abort_release", ifc.o_bus_req, 0);
        chk("abort_idle", ifc.o_busy, 0);
        chk("abort_no_tx_after", ifc.o_tx_valid, 0);
        ifc.i_active = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [15:0] a;
        logic [7:0]  d0;
        logic [7:0]  d1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        rst             = 1'b1;
        ifc.i_active    = 1'b0;
        ifc.i_rx_valid  = 1'b0;
        ifc.i_rx_start  = 1'b0;
        ifc.i_rx_data   = 8'h00;
        ifc.i_tx_ready  = 1'b0;
        ifc.i_bus_ack   = 1'b0;
        ifc.i_bus_rdata = 8'h00;
        #3;
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        ifc.i_active = 1'b1;
        tick();

        // Directed write 0x1234 = AA, BB with ack after 3 cycles, then read back
        q = {8'hAA, 8'hBB};
        write_txn(16'h1234, q, 3);
        read_txn(16'h1234, 2);

        // Read across the top of the address space
        mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'hC3;
        read_txn(16'hFFFF, 2);

        // Deselect while a reply is held
        send(1'b1, 8'h02);
        send(1'b0, 8'h00);
        send(1'b0, 8'h10);
        bus_ack(mem[16'h0010]);
        chk("rhold_tx_valid", ifc.o_tx_valid, 1);
        chk("rhold_tx_data", ifc.o_tx_data, mem[16'h0010]);
        ifc.i_active = 1'b0;
        tick();
        chk("rhold_abort_tx_valid", ifc.o_tx_valid, 0);
        chk("rhold_abort_busy", ifc.o_busy, 0);
        ifc.i_active = 1'b1;
        tick();

        // Random write bursts read back through the model
        for (int r = 0; r < 4; r++) begin
            a = 16'($urandom);
            q = {};
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) q.push_back(8'($urandom));
            write_txn(a, q, -1);
            read_txn(a, q.size());
        end

        // Bad command: everything ignored until deselect, then STATUS reports it once
        send(1'b1, 8'h7E);
        exp_bad = 1'b1;
        send(1'b0, 8'h00);
        send(1'b0, 8'h01);
        send(1'b1, 8'h01);
        chk("discard_busy", ifc.o_busy, 1);
        chk("discard_no_req", ifc.o_bus_req, 0);
        send(1'b0, 8'h02);
        chk("discard_still_no_req", ifc.o_bus_req, 0);
        deselect();
        status_txn();
        status_txn();

        // Command byte mid-address restarts decoding
        send(1'b1, 8'h01);
        send(1'b0, 8'h12);
        send(1'b1, 8'h03);
        chk("resync_tx_valid", ifc.o_tx_valid, 1);
        chk("resync_tx_data", ifc.o_tx_data, 8'h00);
        tx_take();
        chk("resync_idle", ifc.o_busy, 0);

        // Overrun: data byte arriving while the write is still on the bus
        a  = 16'($urandom);
        d0 = 8'($urandom);
        d1 = ~d0;
        send(1'b1, 8'h01);
        send(1'b0, a[15:8]);
        send(1'b0, a[7:0]);
        send(1'b0, d0);
        chk("ovr_req", ifc.o_bus_req, 1);
        tick(5);
        send(1'b0, d1);
        exp_overrun = 1'b1;
        chk("ovr_req_held", ifc.o_bus_req, 1);
        chk("ovr_wdata_stable", ifc.o_bus_wdata, d0);
        chk("ovr_addr_stable", ifc.o_bus_addr, a);
        tick(13);
        chk("ovr_req_late", ifc.o_bus_req, 1);
        bus_ack(8'h00);
        mem[a] = d0;
        chk("ovr_release", ifc.o_bus_req, 0);
        tick(2);
        chk("ovr_dropped_no_req", ifc.o_bus_req, 0);
        deselect();
        status_txn();
        status_txn();
        read_txn(a, 1);

        // Asynchronous reset between edges while a write is outstanding
        send(1'b1, 8'h01);
        send(1'b0, 8'hA5);
        send(1'b0, 8'h5A);
        send(1'b0, 8'h77);
        chk("async_pre_req", ifc.o_bus_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        #2;
        rst = 1'b0;
        tick();
        a = 16'($urandom);
        q = {8'($urandom), 8'($urandom)};
        write_txn(a, q, -1);
        read_txn(a, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
